// File: rtl/ctrl_pipe_hazard_if.sv
// Decoder-to-pipeline control interface.
// Carries ID-stage control in and staged control/hazard selects out.
interface ctrl_pipe_hazard_if #(
    parameter int RA_W = 5
);
    logic            id_valid;
    logic [12:0]     id_ctrl;
    logic [RA_W-1:0] id_rs;
    logic [RA_W-1:0] id_rt;
    logic [RA_W-1:0] id_rd;
    logic            ex_zero;

    logic [12:0]     ex_ctrl;
    logic [12:0]     mem_ctrl;
    logic [12:0]     wb_ctrl;
    logic [RA_W-1:0] ex_rs;
    logic [RA_W-1:0] ex_rt;
    logic [RA_W-1:0] ex_dst;
    logic [RA_W-1:0] mem_dst;
    logic [RA_W-1:0] wb_dst;
    logic            pc_write;
    logic            ifid_write;
    logic            if_flush;
    logic [1:0]      pc_sel;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;

    modport master (
        output id_valid, id_ctrl, id_rs, id_rt, id_rd, ex_zero,
        input  ex_ctrl, mem_ctrl, wb_ctrl, ex_rs, ex_rt,
        input  ex_dst, mem_dst, wb_dst,
        input  pc_write, ifid_write, if_flush, pc_sel, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_ctrl, id_rs, id_rt, id_rd, ex_zero,
        output ex_ctrl, mem_ctrl, wb_ctrl, ex_rs, ex_rt,
        output ex_dst, mem_dst, wb_dst,
        output pc_write, ifid_write, if_flush, pc_sel, fwd_a, fwd_b
    );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// Control pipeline ID/EX, EX/MEM, MEM/WB with destination resolution,
// load-use stall, branch/jump redirect and EX operand forwarding.
module ctrl_pipe_hazard #(
    parameter int RA_W     = 5,
    parameter int LINK_REG = 31
) (
    input logic               clk,
    input logic               reset,
    ctrl_pipe_hazard_if.slave bus
);
    // ctrl = {RegDst[1:0],MemtoReg[1:0],ALUOp[1:0],Jump,Branch,
    //         MemRead,MemWrite,ALUSrc,RegWrite,sign_or_zero}
    localparam logic [12:0]     BUBBLE = 13'h0001;
    localparam logic [RA_W-1:0] LINK   = RA_W'(LINK_REG);
    localparam int B_JUMP   = 6;
    localparam int B_BRANCH = 5;
    localparam int B_MEMRD  = 4;
    localparam int B_REGWR  = 1;

    logic            ex_valid, mem_valid, wb_valid;
    logic [12:0]     ex_ctrl, mem_ctrl, wb_ctrl;
    logic [RA_W-1:0] ex_dst, mem_dst, wb_dst;
    logic [RA_W-1:0] ex_rs, ex_rt;
    logic [RA_W-1:0] id_dst;
    logic            load_use, taken, stall, jump;
    logic            mem_wr, wb_wr;
    logic [1:0]      pc_sel, fwd_a, fwd_b;

    // Resolve the write register of the ID instruction
    always_comb begin
        id_dst = '0;
        unique case (bus.id_ctrl[12:11])
            2'b00:   id_dst = bus.id_rt;
            2'b01:   id_dst = bus.id_rd;
            2'b10:   id_dst = LINK;
            default: id_dst = '0;
        endcase
    end

    assign load_use = ex_valid && ex_ctrl[B_MEMRD] && (ex_dst != '0)
                   && bus.id_valid
                   && ((ex_dst == bus.id_rs) || (ex_dst == bus.id_rt));
    assign taken = ex_valid && ex_ctrl[B_BRANCH] && bus.ex_zero;
    // A taken branch squashes the ID instruction, so its hazard is moot
    assign stall = load_use && !taken;
    assign jump  = bus.id_valid && bus.id_ctrl[B_JUMP] && !load_use && !taken;

    assign mem_wr = mem_valid && mem_ctrl[B_REGWR] && (mem_dst != '0);
    assign wb_wr  = wb_valid && wb_ctrl[B_REGWR] && (wb_dst != '0);

    // Redirect select: taken branch outranks jump
    always_comb begin
        pc_sel = 2'b00;
        unique case (1'b1)
            taken:   pc_sel = 2'b10;
            jump:    pc_sel = 2'b01;
            default: pc_sel = 2'b00;
        endcase
    end

    // Forwarding: youngest producer (EX/MEM) wins over MEM/WB
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_wr && (mem_dst == ex_rs))
            fwd_a = 2'b10;
        else if (wb_wr && (wb_dst == ex_rs))
            fwd_a = 2'b01;
        if (mem_wr && (mem_dst == ex_rt))
            fwd_b = 2'b10;
        else if (wb_wr && (wb_dst == ex_rt))
            fwd_b = 2'b01;
    end

    // Advance ID->EX, inserting a bubble on stall, redirect or invalid ID
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= BUBBLE;
            ex_dst   <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
        end else if (taken || stall || !bus.id_valid) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= BUBBLE;
            ex_dst   <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
        end else begin
            ex_valid <= 1'b1;
            ex_ctrl  <= bus.id_ctrl;
            ex_dst   <= id_dst;
            ex_rs    <= bus.id_rs;
            ex_rt    <= bus.id_rt;
        end
    end

    // Advance EX->MEM->WB unconditionally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid <= 1'b0;
            mem_ctrl  <= BUBBLE;
            mem_dst   <= '0;
            wb_valid  <= 1'b0;
            wb_ctrl   <= BUBBLE;
            wb_dst    <= '0;
        end else begin
            mem_valid <= ex_valid;
            mem_ctrl  <= ex_ctrl;
            mem_dst   <= ex_dst;
            wb_valid  <= mem_valid;
            wb_ctrl   <= mem_ctrl;
            wb_dst    <= mem_dst;
        end
    end

    assign bus.ex_ctrl    = ex_ctrl;
    assign bus.mem_ctrl   = mem_ctrl;
    assign bus.wb_ctrl    = wb_ctrl;
    assign bus.ex_rs      = ex_rs;
    assign bus.ex_rt      = ex_rt;
    assign bus.ex_dst     = ex_dst;
    assign bus.mem_dst    = mem_dst;
    assign bus.wb_dst     = wb_dst;
    assign bus.pc_write   = !stall;
    assign bus.ifid_write = !stall;
    assign bus.if_flush   = taken || jump;
    assign bus.pc_sel     = pc_sel;
    assign bus.fwd_a      = fwd_a;
    assign bus.fwd_b      = fwd_b;
endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Scoreboard bench for ctrl_pipe_hazard: directed ID vectors with
// hand-computed per-cycle expectations, checked by a negedge monitor.
module tb_ctrl_pipe_hazard;
    localparam logic [12:0] NOP  = 13'h0001;
    localparam logic [12:0] ADD  = 13'h0903;
    localparam logic [12:0] LW   = 13'h0217;
    localparam logic [12:0] BEQ  = 13'h00A1;
    localparam logic [12:0] JAL  = 13'h1443;
    localparam logic [12:0] LDBR = 13'h00B1;

    typedef struct {
        int          tag;
        logic        pcw;
        logic        ifw;
        logic        fl;
        logic [1:0]  sel;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [12:0] exc;
        logic [4:0]  exd;
        logic [4:0]  md;
        logic [4:0]  wd;
        logic [12:0] mc;
        logic [12:0] wc;
    } exp_t;

    logic clk;
    logic reset;
    int   passed;
    int   total;
    int   step_no;
    exp_t q[$];

    ctrl_pipe_hazard_if #(.RA_W(5)) bus ();

    ctrl_pipe_hazard #(.RA_W(5), .LINK_REG(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int tag, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL step %0d %s: got %0h expected %0h",
                     tag, name, act, exp);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.tag, "pc_write",   32'(bus.pc_write),   32'(e.pcw));
            chk(e.tag, "ifid_write", 32'(bus.ifid_write), 32'(e.ifw));
            chk(e.tag, "if_flush",   32'(bus.if_flush),   32'(e.fl));
            chk(e.tag, "pc_sel",     32'(bus.pc_sel),     32'(e.sel));
            chk(e.tag, "fwd_a",      32'(bus.fwd_a),      32'(e.fa));
            chk(e.tag, "fwd_b",      32'(bus.fwd_b),      32'(e.fb));
            chk(e.tag, "ex_ctrl",    32'(bus.ex_ctrl),    32'(e.exc));
            chk(e.tag, "ex_dst",     32'(bus.ex_dst),     32'(e.exd));
            chk(e.tag, "mem_dst",    32'(bus.mem_dst),    32'(e.md));
            chk(e.tag, "wb_dst",     32'(bus.wb_dst),     32'(e.wd));
            if (e.mc !== 13'h1fff)
                chk(e.tag, "mem_ctrl", 32'(bus.mem_ctrl), 32'(e.mc));
            if (e.wc !== 13'h1fff)
                chk(e.tag, "wb_ctrl",  32'(bus.wb_ctrl),  32'(e.wc));
        end
    end

    task automatic push(input logic pcw, input logic ifw, input logic fl,
                        input logic [1:0] sel, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [12:0] exc,
                        input int exd, input int md, input int wd,
                        input logic [12:0] mc, input logic [12:0] wc);
        exp_t e;
        e.tag = step_no;
        e.pcw = pcw;
        e.ifw = ifw;
        e.fl  = fl;
        e.sel = sel;
        e.fa  = fa;
        e.fb  = fb;
        e.exc = exc;
        e.exd = 5'(exd);
        e.md  = 5'(md);
        e.wd  = 5'(wd);
        e.mc  = mc;
        e.wc  = wc;
        q.push_back(e);
        step_no++;
    endtask

    // One cycle: drive ID inputs just after the edge, queue the expectation
    task automatic step(input logic rst, input logic v, input logic [12:0] c,
                        input int rs, input int rt, input int rd,
                        input logic z, input logic pcw, input logic ifw,
                        input logic fl, input logic [1:0] sel,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic [12:0] exc, input int exd,
                        input int md, input int wd);
        @(posedge clk);
        #1;
        reset        = rst;
        bus.id_valid = v;
        bus.id_ctrl  = c;
        bus.id_rs    = 5'(rs);
        bus.id_rt    = 5'(rt);
        bus.id_rd    = 5'(rd);
        bus.ex_zero  = z;
        push(pcw, ifw, fl, sel, fa, fb, exc, exd, md, wd,
             13'h1fff, 13'h1fff);
    endtask

    initial begin
        passed       = 0;
        total        = 0;
        step_no      = 0;
        reset        = 1'b0;
        bus.id_valid = 1'b0;
        bus.id_ctrl  = '0;
        bus.id_rs    = '0;
        bus.id_rt    = '0;
        bus.id_rd    = '0;
        bus.ex_zero  = 1'b0;
        #1;
        push(1, 1, 0, 2'b00, 2'b00, 2'b00, NOP, 0, 0, 0, NOP, NOP);
        @(negedge clk);
        #2;
        reset = 1'b1;

        // rst v  ctrl  rs rt rd z   pcw ifw fl sel    fa     fb     exc  exd md wd
        step(1, 1, LW,    1, 2, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, NOP,   0, 0, 0);
        step(1, 1, ADD,   2, 4, 3, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, LW,    2, 0, 0);
        step(1, 1, ADD,   2, 4, 3, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, NOP,   0, 2, 0);
        step(1, 1, ADD,   1, 1, 5, 0, 1, 1, 0, 2'b00, 2'b01, 2'b00, ADD,   3, 0, 2);
        step(1, 1, ADD,   5, 5, 6, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, ADD,   5, 3, 0);
        step(1, 1, LDBR,  7, 8, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, ADD,   6, 5, 3);
        step(1, 1, ADD,   8, 1, 9, 1, 1, 1, 1, 2'b10, 2'b00, 2'b00, LDBR,  8, 6, 5);
        step(1, 1, JAL,   0, 0, 0, 0, 1, 1, 1, 2'b01, 2'b00, 2'b00, NOP,   0, 8, 6);
        step(1, 1, BEQ,   3, 4, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, JAL,  31, 0, 8);
        step(1, 1, JAL,   0, 0, 0, 1, 1, 1, 1, 2'b10, 2'b00, 2'b00, BEQ,   4,31, 0);
        step(1, 1, ADD,   1, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, NOP,   0, 4,31);
        step(1, 1, ADD,   0, 0,10, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, ADD,   0, 0, 4);
        step(1, 1, LW,    1, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, ADD,  10, 0, 0);
        step(1, 1, ADD,   0, 0,11, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, LW,    0,10, 0);
        step(1, 1, LW,    1,12, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, ADD,  11, 0,10);
        step(1, 1, ADD,   1,12,13, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, LW,   12,11, 0);
        step(1, 1, ADD,   1,12,13, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, NOP,   0,12,11);
        step(1, 1, ADD,  13,12,14, 0, 1, 1, 0, 2'b00, 2'b00, 2'b01, ADD,  13, 0,12);
        step(1, 0, JAL,  14,14, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b00, ADD,  14,13, 0);
        step(1, 1, ADD,  14,14,16, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, NOP,   0,14,13);
        step(1, 1, ADD,   1, 1,14, 0, 1, 1, 0, 2'b00, 2'b01, 2'b01, ADD,  16, 0,14);
        step(1, 1, ADD,   2, 2,14, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, ADD,  14,16, 0);
        step(1, 1, ADD,  14,16,17, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, ADD,  14,14,16);
        step(1, 0, NOP,   0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b00, ADD,  17,14,14);
        step(0, 0, NOP,   0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, NOP,   0, 0, 0);
        step(1, 0, NOP,   0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, NOP,   0, 0, 0);

        for (int i = 0; i < 4 && q.size() > 0; i++)
            @(negedge clk);
        #1;
        total++;
        if (q.size() == 0)
            passed++;
        else
            $display("FAIL drain: got %0d pending expected 0", q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
